// File: rtl/cpu_types_pkg.sv
// Shared cache types: controller state encoding, data word, and address-field
// width helpers derived from the cache geometry parameters.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} dcache_state_t;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int boff_w(input int blkwords);
        return $clog2(blkwords);
    endfunction

    function automatic int tag_w(input int sets, input int blkwords);
        return 30 - idx_w(sets) - boff_w(blkwords);
    endfunction

    // Selector widths never collapse to zero so degenerate geometries still elaborate.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int cnt_w(input int blkwords);
        return (blkwords > 1) ? $clog2(blkwords) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age tracker: one age per way per set, an access/fill update port and
// a victim selector (lowest invalid way, otherwise the oldest way).
module dcache_lru import cpu_types_pkg::*; #(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     upd_en,
    input  logic                     upd_fill,
    input  logic [idx_w(SETS)-1:0]   upd_set,
    input  logic [way_w(WAYS)-1:0]   upd_way,
    input  logic [idx_w(SETS)-1:0]   vic_set,
    input  logic [WAYS-1:0]          vic_valid,
    output logic [way_w(WAYS)-1:0]   vic_way
);

    localparam int WAY_W = way_w(WAYS);

    if (WAYS == 1) begin : g_dm
        logic unused_lru;
        assign unused_lru = &{1'b0, CLK, nRST, upd_en, upd_fill, upd_set, upd_way, vic_set, vic_valid};
        assign vic_way = '0;
    end else begin : g_lru
        localparam int AGE_W = $clog2(WAYS);
        localparam logic [AGE_W-1:0] OLDEST = AGE_W'(WAYS - 1);

        logic [AGE_W-1:0] age [SETS][WAYS];
        logic [AGE_W-1:0] old_age;

        // A fill treats the incoming way as oldest, so valid ways keep distinct ages.
        assign old_age = upd_fill ? OLDEST : age[upd_set][upd_way];

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                for (int unsigned s = 0; s < SETS; s++)
                    for (int unsigned w = 0; w < WAYS; w++)
                        age[s][w] <= '0;
            end else if (upd_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == upd_way)
                        age[upd_set][w] <= '0;
                    else if (age[upd_set][w] < old_age)
                        age[upd_set][w] <= age[upd_set][w] + 1'b1;
                end
            end
        end

        always_comb begin
            vic_way = '0;
            if (&vic_valid) begin
                for (int unsigned w = 0; w < WAYS; w++)
                    if (age[vic_set][w] == OLDEST) vic_way = WAY_W'(w);
            end else begin
                for (int unsigned i = 0; i < WAYS; i++)
                    if (!vic_valid[WAYS-1-i]) vic_way = WAY_W'(WAYS - 1 - i);
            end
        end
    end

endmodule

// File: rtl/assoc_dcache.sv
// N-way set-associative write-back, write-allocate data cache with LRU and
// halt-triggered flush. Optional hit counter port: define DCACHE_HITCOUNT_EN.
module assoc_dcache import cpu_types_pkg::*; #(
    parameter int SETS     = 8,
    parameter int WAYS     = 2,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
`ifdef DCACHE_HITCOUNT_EN
    ,
    output logic [31:0] hitcount
`endif
);

    localparam int IDX_W  = idx_w(SETS);
    localparam int BOFF_W = boff_w(BLKWORDS);
    localparam int TAG_W  = tag_w(SETS, BLKWORDS);
    localparam int WAY_W  = way_w(WAYS);
    localparam int CNT_W  = cnt_w(BLKWORDS);
    localparam int WAYB   = $clog2(WAYS);
    localparam int PTR_W  = $clog2(SETS * WAYS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLKWORDS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SETS * WAYS - 1);

    logic [WAYS-1:0]  valid [SETS];
    logic [WAYS-1:0]  dirty [SETS];
    logic [TAG_W-1:0] tags  [SETS][WAYS];
    word_t            data  [SETS][WAYS][BLKWORDS];

    dcache_state_t    state, next_state;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PTR_W-1:0] fptr, fptr_n;
    logic [WAY_W-1:0] vway, vway_n, hit_way, vic_way, lru_way, fway;
    logic [IDX_W-1:0] req_idx, fset;
    logic [TAG_W-1:0] req_tag;
    logic [CNT_W-1:0] req_off;
    logic             req, hit, miss, lru_en, lru_fill, wr_hit, fill_we, fill_last, flush_clr;
    logic             unused_addr;

    assign unused_addr = &{1'b0, dmemaddr[1:0]};
    assign req     = dmemREN | dmemWEN;
    assign req_tag = dmemaddr[31 -: TAG_W];
    assign req_idx = dmemaddr[BOFF_W+2 +: IDX_W];
    assign req_off = (BOFF_W == 0) ? '0 : CNT_W'(dmemaddr[31:2]);
    assign fset    = IDX_W'(fptr >> WAYB);
    assign fway    = (WAYS == 1) ? '0 : WAY_W'(fptr);

    function automatic word_t blk_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                                       input logic [CNT_W-1:0] c);
        return {t, i, {(BOFF_W + 2){1'b0}}} | (word_t'(c) << 2);
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++)
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
    end

    dcache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .CLK       (CLK),
        .nRST      (nRST),
        .upd_en    (lru_en),
        .upd_fill  (lru_fill),
        .upd_set   (req_idx),
        .upd_way   (lru_way),
        .vic_set   (req_idx),
        .vic_valid (valid[req_idx]),
        .vic_way   (vic_way)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
            fptr  <= '0;
            vway  <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_n;
            fptr  <= fptr_n;
            vway  <= vway_n;
        end
    end

    always_comb begin
        next_state = state;
        cnt_n      = cnt;
        fptr_n     = fptr;
        vway_n     = vway;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        miss       = 1'b0;
        lru_en     = 1'b0;
        lru_fill   = 1'b0;
        lru_way    = hit_way;
        wr_hit     = 1'b0;
        fill_we    = 1'b0;
        fill_last  = 1'b0;
        flush_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (req && hit) begin
                    dhit     = 1'b1;
                    dmemload = data[req_idx][hit_way][req_off];
                    lru_en   = 1'b1;
                    wr_hit   = dmemWEN;
                end else if (req) begin
                    miss       = 1'b1;
                    vway_n     = vic_way;
                    cnt_n      = '0;
                    next_state = (valid[req_idx][vic_way] && dirty[req_idx][vic_way]) ? WB : FETCH;
                end else if (halt) begin
                    fptr_n     = '0;
                    cnt_n      = '0;
                    next_state = FLUSH;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(tags[req_idx][vway], req_idx, cnt);
                dstore = data[req_idx][vway][cnt];
                if (!dwait) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        cnt_n      = '0;
                        next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = blk_addr(req_tag, req_idx, cnt);
                if (!dwait) begin
                    fill_we = 1'b1;
                    cnt_n   = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        fill_last  = 1'b1;
                        lru_en     = 1'b1;
                        lru_fill   = 1'b1;
                        lru_way    = vway;
                        cnt_n      = '0;
                        next_state = IDLE;
                    end
                end
            end
            FLUSH: begin
                // Clean or invalid lines advance immediately; dirty ones stream out first.
                if (valid[fset][fway] && dirty[fset][fway]) begin
                    dWEN   = 1'b1;
                    daddr  = blk_addr(tags[fset][fway], fset, cnt);
                    dstore = data[fset][fway][cnt];
                    if (!dwait) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            cnt_n     = '0;
                            flush_clr = 1'b1;
                            if (fptr == LAST_PTR) next_state = DONE;
                            else                  fptr_n     = fptr + 1'b1;
                        end
                    end
                end else begin
                    if (fptr == LAST_PTR) next_state = DONE;
                    else                  fptr_n     = fptr + 1'b1;
                end
            end
            DONE: flushed = 1'b1;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
        end else begin
            if (wr_hit)    dirty[req_idx][hit_way] <= 1'b1;
            if (fill_last) begin
                valid[req_idx][vway] <= 1'b1;
                dirty[req_idx][vway] <= 1'b0;
            end
            if (flush_clr) dirty[fset][fway] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_hit)    data[req_idx][hit_way][req_off] <= dmemstore;
        if (fill_we)   data[req_idx][vway][cnt]        <= dload;
        if (fill_last) tags[req_idx][vway]             <= req_tag;
    end

`ifdef DCACHE_HITCOUNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)     hitcount <= '0;
        else if (dhit) hitcount <= hitcount + 32'd1;
        else if (miss) hitcount <= hitcount - 32'd1;
    end
`endif

endmodule

// File: tb/tb_assoc_dcache.sv
// Scoreboard bench for assoc_dcache: a flat-memory + MRU-list reference model
// predicts load data, memory traffic, evictions and flush contents.
`timescale 1ns/1ps
module tb_assoc_dcache;

    localparam int SETS      = 8;
    localparam int WAYS      = 2;
    localparam int BLKWORDS  = 2;
    localparam int BLK_BYTES = BLKWORDS * 4;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0, dwait = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0, dload = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    assoc_dcache #(.SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } exp_t;

    int          total = 0, bad = 0;
    exp_t        sbq[$];
    logic [31:0] rdq[$], wbq_a[$], wbq_d[$];
    logic [31:0] truth [bit [31:0]];
    logic [31:0] mem   [bit [31:0]];
    logic [31:0] fexp  [bit [31:0]];
    logic [31:0] mtag  [SETS][$];
    bit          mdirty [bit [31:0]];
    bit          flushing = 0;
    int          fcount = 0, wlo = 0, whi = 0, wcnt = 0, wtarget = 0;
    bit          have_prev = 0;
    logic [65:0] prev;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hCAFE0000 + ((a >> 2) - 32'h40);
    endfunction

    function automatic logic [31:0] tget(input logic [31:0] a);
        return truth.exists(a) ? truth[a] : init_val(a);
    endfunction

    function automatic logic [31:0] mget(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic set_wait(input int lo, input int hi);
        wlo = lo; whi = hi; wtarget = $urandom_range(hi, lo);
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) mtag[s].delete();
        mdirty.delete();
    endtask

    // Reference: each set is an MRU-first list of tags; memory is flat.
    task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] d, output bit hit);
        int          set, pos;
        logic [31:0] tag, blk, vt, vblk;
        set = int'((a / BLK_BYTES) % SETS);
        tag = a / (BLK_BYTES * SETS);
        blk = a - (a % BLK_BYTES);
        pos = -1;
        for (int i = 0; i < mtag[set].size(); i++) if (mtag[set][i] == tag) pos = i;
        hit = (pos >= 0);
        if (hit) mtag[set].delete(pos);
        else begin
            if (mtag[set].size() == WAYS) begin
                vt   = mtag[set].pop_back();
                vblk = vt * (BLK_BYTES * SETS) + set * BLK_BYTES;
                if (mdirty.exists(vblk)) begin
                    for (int i = 0; i < BLKWORDS; i++) begin
                        wbq_a.push_back(vblk + 4 * i);
                        wbq_d.push_back(tget(vblk + 4 * i));
                    end
                    mdirty.delete(vblk);
                end
            end
            for (int i = 0; i < BLKWORDS; i++) rdq.push_back(blk + 4 * i);
        end
        mtag[set].push_front(tag);
        if (we) begin
            mdirty[blk] = 1'b1;
            truth[a]    = d;
        end
    endtask

    task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit   hit;
        int   n;
        exp_t e;
        e.we = we; e.addr = a; e.data = we ? d : tget(a);
        model_access(we, a, d, hit);
        sbq.push_back(e);
        dmemaddr = a; dmemstore = d; dmemREN = !we; dmemWEN = we;
        n = 0;
        do begin @(negedge CLK); n++; end while (!dhit && n < 400);
        total++;
        if (!dhit) begin
            bad++;
            $display("FAIL access_timeout addr=%h got_cycles=%0d want=dhit", a, n);
        end else if (hit && n != 1) begin
            bad++;
            $display("FAIL hit_latency addr=%h got=%0d want=1", a, n);
        end else if (!hit && n < 2) begin
            bad++;
            $display("FAIL miss_latency addr=%h got=%0d want>=2", a, n);
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (nRST && dhit) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_dhit addr=%h got=1 want=0", dmemaddr);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (!e.we) begin
                    total++;
                    if (dmemload !== e.data) begin
                        bad++;
                        $display("FAIL load_data addr=%h got=%h want=%h", e.addr, dmemload, e.data);
                    end
                end
            end
        end
    end

    // Memory slave: decides dwait each cycle and checks every accepted word.
    always @(negedge CLK) begin
        if (!nRST) begin
            dwait = 1'b0; wcnt = 0; have_prev = 0;
        end else begin
            if (have_prev) begin
                total++;
                if ({dREN, dWEN, daddr, dstore} !== prev) begin
                    bad++;
                    $display("FAIL stall_stable got=%h want=%h", {dREN, dWEN, daddr, dstore}, prev);
                end
            end
            have_prev = 0;
            if (dREN || dWEN) begin
                if (wcnt < wtarget) begin
                    dwait = 1'b1; wcnt++; have_prev = 1;
                    prev = {dREN, dWEN, daddr, dstore};
                end else begin
                    dwait = 1'b0; wcnt = 0; wtarget = $urandom_range(whi, wlo);
                    total++;
                    if (dREN) begin
                        if (rdq.size() == 0) begin
                            bad++; $display("FAIL unexpected_read got=%h want=none", daddr);
                        end else if (daddr !== rdq[0]) begin
                            bad++; $display("FAIL read_addr got=%h want=%h", daddr, rdq[0]);
                        end
                        if (rdq.size() != 0) void'(rdq.pop_front());
                        dload = mget(daddr);
                    end else if (flushing) begin
                        if (!fexp.exists(daddr)) begin
                            bad++; $display("FAIL flush_addr got=%h want=dirty_word", daddr);
                        end else begin
                            if (dstore !== fexp[daddr]) begin
                                bad++; $display("FAIL flush_data addr=%h got=%h want=%h", daddr, dstore, fexp[daddr]);
                            end
                            fexp.delete(daddr);
                        end
                        fcount++;
                        mem[daddr] = dstore;
                    end else begin
                        if (wbq_a.size() == 0) begin
                            bad++; $display("FAIL unexpected_write got=%h want=none", daddr);
                        end else begin
                            if (daddr !== wbq_a[0] || dstore !== wbq_d[0]) begin
                                bad++;
                                $display("FAIL writeback got=%h/%h want=%h/%h", daddr, dstore, wbq_a[0], wbq_d[0]);
                            end
                            void'(wbq_a.pop_front()); void'(wbq_d.pop_front());
                        end
                        mem[daddr] = dstore;
                    end
                end
            end else dwait = 1'b0;
        end
    end

    initial begin
        bit hit;
        int n, fexp_n;
        exp_t e;

        #3;
        chk("reset_dhit", 32'(dhit), 0);
        chk("reset_dREN", 32'(dREN), 0);
        chk("reset_dWEN", 32'(dWEN), 0);
        chk("reset_daddr", daddr, 0);
        chk("reset_dstore", dstore, 0);
        chk("reset_flushed", 32'(flushed), 0);
        chk("reset_dmemload", dmemload, 0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;

        set_wait(0, 0);
        do_access(0, 32'h100, 0);
        do_access(0, 32'h104, 0);
        do_access(1, 32'h100, 32'h11);
        do_access(0, 32'h140, 0);
        do_access(0, 32'h100, 0);
        do_access(0, 32'h180, 0);
        do_access(0, 32'h100, 0);
        set_wait(3, 3);
        do_access(1, 32'h184, 32'h22);
        do_access(0, 32'h1C0, 0);
        do_access(0, 32'h100, 0);

        set_wait(0, 2);
        repeat (300) do_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 95) * 4), $urandom);
        do_access(1, 32'h000, 32'hA5A5_0001);
        do_access(1, 32'h040, 32'hA5A5_0002);

        fexp_n = 0;
        for (int s = 0; s < SETS; s++)
            for (int i = 0; i < mtag[s].size(); i++) begin
                logic [31:0] blk;
                blk = mtag[s][i] * (BLK_BYTES * SETS) + s * BLK_BYTES;
                if (mdirty.exists(blk))
                    for (int w = 0; w < BLKWORDS; w++) begin
                        fexp[blk + 4 * w] = tget(blk + 4 * w);
                        fexp_n++;
                    end
            end
        flushing = 1; fcount = 0; halt = 1'b1;
        n = 0;
        while (!flushed && n < 3000) begin @(negedge CLK); n++; end
        chk("flush_done", 32'(flushed), 1);
        chk("flush_words", 32'(fcount), 32'(fexp_n));
        chk("flush_leftover", 32'(fexp.num()), 0);

        dmemaddr = 32'h100; dmemREN = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("done_dhit", 32'(dhit), 0);
            chk("done_flushed", 32'(flushed), 1);
            chk("done_mem_idle", 32'({dREN, dWEN}), 0);
        end
        dmemREN = 1'b0; halt = 1'b0; flushing = 0;

        @(posedge CLK); #2; nRST = 1'b0; #1;
        chk("reset2_flushed", 32'(flushed), 0);
        model_clear();
        @(negedge CLK); #2; nRST = 1'b1;
        @(posedge CLK); #1;

        set_wait(3, 3);
        e.we = 0; e.addr = 32'h200; e.data = tget(32'h200);
        model_access(0, 32'h200, 0, hit);
        sbq.push_back(e);
        dmemaddr = 32'h200; dmemREN = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!dREN && n < 50);
        chk("abort_fetch_started", 32'(dREN), 1);
        @(negedge CLK); #2; nRST = 1'b0; #1;
        chk("abort_dREN", 32'(dREN), 0);
        chk("abort_daddr", daddr, 0);
        chk("abort_dhit", 32'(dhit), 0);
        dmemREN = 1'b0;
        sbq.delete(); rdq.delete(); wbq_a.delete(); wbq_d.delete();
        model_clear();
        @(negedge CLK); #2; nRST = 1'b1;
        @(posedge CLK); #1;
        do_access(0, 32'h200, 0);
        do_access(0, 32'h204, 0);

        repeat (3) @(negedge CLK);
        chk("sbq_empty", 32'(sbq.size()), 0);
        chk("rdq_empty", 32'(rdq.size()), 0);
        chk("wbq_empty", 32'(wbq_a.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/assoc_dcache.md
# assoc_dcache

Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the datapath's data port and the memory controller's data channel. Generalises the fixed 2-way, 8-set, 2-word dcache to configurable set count, associativity and block size. Adds true LRU replacement, dirty-victim writeback and a halt-triggered flush of all dirty lines.

## Interface
Parameters:
- SETS, 8, number of sets; power of two, ≥2
- WAYS, 2, associativity; power of two, 1–8
- BLKWORDS, 2, 32-bit words per block; power of two, ≥1

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- dmemREN  in  1  datapath load request
- dmemWEN  in  1  datapath store request; never asserted together with dmemREN
- dmemaddr  in  32  word-aligned byte address
- dmemstore  in  32  store data
- halt  in  1  level; starts a flush
- dhit  out  1  request completed this cycle
- dmemload  out  32  load data, valid when dhit
- flushed  out  1  flush complete; sticky until reset
- dREN, dWEN  out  1  memory read/write request
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; a word transfers in the cycle dwait=0 with dREN or dWEN high

## Operation
- Address split, LSB up: 2-bit byte offset, BOFF_W=$clog2(BLKWORDS) block offset, IDX_W=$clog2(SETS) index, the remaining bits as tag.
- Line state: valid, dirty, tag, BLKWORDS words. LRU age per way is $clog2(WAYS) bits.
- On access, the hit way's age becomes 0. Ways younger than its old age increment by 1.
- Victim: the lowest-index invalid way. If every way is valid, the way with age WAYS-1.
- State machine: IDLE, WB, FETCH, FLUSH, DONE.
- IDLE, read hit: dhit=1; dmemload=word; LRU updates.
- IDLE, write hit: dhit=1; the word and dirty=1 are written at the next edge; LRU updates.
- IDLE, miss:
  - dirty victim -> WB
  - clean victim -> FETCH
  - word counter cleared
- WB: dWEN=1; daddr={victim tag, idx, cnt, 2'b00}; dstore=victim word[cnt]. cnt increments on each dwait=0. After the last word -> FETCH, cnt=0.
- FETCH: dREN=1; daddr={req tag, idx, cnt, 2'b00}. dload is captured into way word[cnt] on dwait=0. After the last word, the line becomes valid, clean, with the new tag -> IDLE. The request then hits the next cycle.
- IDLE with halt=1 and no miss in progress -> FLUSH. A miss in progress completes first.
- FLUSH: scans set/way (set-major) pointer 0..SETS*WAYS-1. Each dirty line is written back word by word using the WB addressing, then cleared. Clean lines are skipped in one cycle. After the last line -> DONE.
- DONE: flushed=1; dhit=0; no memory requests. Left only by reset.
- dhit is never asserted outside IDLE.

## Timing
- Reset (async): all valid/dirty/age cleared, state=IDLE, counters 0. Every output is 0.
- Hit latency: 0 cycles (combinational dhit in the request cycle).
- Clean miss: BLKWORDS transfers, then the hit on the following cycle.
- Dirty miss: 2×BLKWORDS transfers, then the hit on the following cycle.
- Outputs are held stable while dwait=1. daddr/dstore change only after an accepted word.
- Requests may be dropped by the datapath only after dhit; the cache holds its state regardless.
- Reset mid-WB/FETCH: the transaction is abandoned and all lines are invalid.
- WAYS=1: direct-mapped, with age logic absent. BLKWORDS=1: BOFF_W=0 and the counter is unused.

## Configuration
- DCACHE_HITCOUNT_EN defined:
  - adds the output port hitcount (32 bits), reset 0.
  - +1 on each IDLE hit, −1 on each miss entry, two's-complement wrap.
  - frozen in DONE.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package (cpu_types_pkg) holds:
  - the state enum dcache_state_t {IDLE, WB, FETCH, FLUSH, DONE}
  - word_t
  - the address-field width functions of the parameters
- Sub-module dcache_lru: a per-set age array with an update port (set, hit way) and a victim-way output. Parametrised by SETS and WAYS.

## Test plan
- Reset, then a load from 0x100 with dload=0xCAFE0000+word -> 2 dREN transfers at 0x100/0x104. dhit follows with dmemload=0xCAFE0000. A reload of 0x104 hits in 0 cycles with 0xCAFE0001.
- Store 0x11 to 0x100 after the fill -> dhit in the same cycle, line dirty, no memory traffic.
- WAYS=2: fill tags A and B in set 0, touch A, then miss on C -> B evicted, and A still hits.
- Dirty victim with dwait held high 3 cycles per word -> WB words at the victim addresses, stable while dwait=1, then FETCH of the new block.
- Two dirty lines then halt=1 -> exactly 2×BLKWORDS dWEN transfers, then flushed=1 held. dhit stays 0 afterwards.
- nRST pulse mid-FETCH -> outputs 0 immediately. The next access to the same address misses.
